// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and constants for the async FIFO read-side drain.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;

    // Occupancy of the 2-entry drain buffer; encoding 3 never occurs
    typedef logic [1:0] buf_cnt_t;

    localparam buf_cnt_t CNT_EMPTY = 2'd0;
    localparam buf_cnt_t CNT_ONE   = 2'd1;
    localparam buf_cnt_t CNT_FULL  = 2'd2;

    function automatic logic buf_has_room(input buf_cnt_t cnt);
        return (cnt < CNT_FULL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// ============================================================================
// Module      : skid_buf2
// Description : Two-entry in-order buffer with push, pop and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_head,
    output buf_cnt_t              o_count
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    buf_cnt_t              r_count;
    logic                  r_valid;

    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic [DATA_WIDTH-1:0] w_tail_nxt;
    buf_cnt_t              w_count_nxt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_push_to_head;

    always_comb begin
        w_head_nxt     = r_head;
        w_tail_nxt     = r_tail;
        w_count_nxt    = r_count;
        w_push         = i_push & buf_has_room(r_count) & ~i_flush;
        w_pop          = i_pop & (r_count != CNT_EMPTY) & ~i_flush;
        // New word lands in head whenever head will be vacant after this edge
        w_push_to_head = (r_count == CNT_EMPTY) | ((r_count == CNT_ONE) & w_pop);

        if (i_flush) begin
            w_count_nxt = CNT_EMPTY;
        end else begin
            if (w_pop) begin
                w_head_nxt = r_tail;
            end
            if (w_push) begin
                if (w_push_to_head) begin
                    w_head_nxt = i_push_data;
                end else begin
                    w_tail_nxt = i_push_data;
                end
            end
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CNT_ONE;
                2'b01:   w_count_nxt = r_count - CNT_ONE;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= CNT_EMPTY;
            r_valid <= 1'b0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != CNT_EMPTY);
        end
    end

    assign o_valid = r_valid;
    assign o_head  = r_head;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_drain
// Description : Read-domain drain of the async FIFO into a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  drain_cnt
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

    buf_cnt_t              w_count;
    logic                  w_valid;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_rinc;
    logic                  w_pop;
    logic [CNT_WIDTH-1:0]  r_drain_cnt;

    // Gate uses only the pre-pop occupancy so out_ready never reaches rinc
    assign w_rinc = ~rrst & en & ~rempty & ~flush & buf_has_room(w_count);
    assign w_pop  = w_valid & out_ready & ~flush;

    skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf2 (
        .clk         (rclk),
        .rst         (rrst),
        .i_push      (w_rinc),
        .i_push_data (rdata),
        .i_pop       (w_pop),
        .i_flush     (flush),
        .o_valid     (w_valid),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_drain_cnt <= '0;
        end else if (w_pop && (r_drain_cnt != C_CNT_MAX)) begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
        end
    end

    assign rinc      = w_rinc;
    assign out_valid = w_valid;
    assign out_data  = w_head;
    assign drain_cnt = r_drain_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_drain
// Description : Directed self-checking bench for fifo_rd_drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_drain;

    logic       rclk;
    logic       rrst;
    logic       en;
    logic       flush;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [3:0] drain_cnt;

    fifo_rd_drain #(
        .DATA_WIDTH (8),
        .CNT_WIDTH  (4)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .en        (en),
        .flush     (flush),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .drain_cnt (drain_cnt)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] q[$];
    logic [7:0] acc[$];
    logic [31:0] rinc_h;
    logic [31:0] vld_h;
    int         cyc;
    logic       s_rinc;
    logic       s_valid;
    logic [7:0] s_data;
    logic [3:0] s_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] acc_at(input int k);
        if (k < acc.size()) return acc[k];
        return 8'hxx;
    endfunction

    task automatic clear_hist();
        cyc    = 0;
        rinc_h = '0;
        vld_h  = '0;
        acc.delete();
    endtask

    // One read-clock cycle: present FIFO state, sample, clock, retire read word
    task automatic cycle();
        rempty = (q.size() == 0);
        rdata  = (q.size() != 0) ? q[0] : 8'h00;
        #1;
        s_rinc  = rinc;
        s_valid = out_valid;
        s_data  = out_data;
        s_cnt   = drain_cnt;
        if (cyc < 32) begin
            rinc_h[cyc] = s_rinc;
            vld_h[cyc]  = s_valid;
        end
        if (s_valid && out_ready && !flush && !rrst) acc.push_back(s_data);
        @(posedge rclk);
        if (s_rinc && q.size() != 0) void'(q.pop_front());
        cyc++;
        @(negedge rclk);
    endtask

    task automatic do_reset();
        rrst = 1'b1; en = 1'b1; flush = 1'b0; out_ready = 1'b0;
        q.delete();
        cycle();
        cycle();
        rrst = 1'b0;
        clear_hist();
    endtask

    initial begin
        rrst = 1'b1; en = 1'b1; flush = 1'b0; out_ready = 1'b0;
        rempty = 1'b1; rdata = 8'h00;
        clear_hist();
        @(negedge rclk);

        // Reset with a non-empty FIFO
        q = '{8'hEE};
        out_ready = 1'b1;
        repeat (3) cycle();
        check_eq("rst_rinc_hist", rinc_h[2:0], 3'b000);
        check_eq("rst_valid", s_valid, 1'b0);
        check_eq("rst_data", s_data, 8'h00);
        check_eq("rst_cnt", s_cnt, 4'd0);

        // Streaming three words
        do_reset();
        q = '{8'hA1, 8'hA2, 8'hA3};
        out_ready = 1'b1;
        repeat (6) cycle();
        check_eq("stream_rinc", rinc_h[5:0], 6'b000111);
        check_eq("stream_valid", vld_h[5:0], 6'b001110);
        check_eq("stream_n", acc.size(), 3);
        check_eq("stream_w0", acc_at(0), 8'hA1);
        check_eq("stream_w1", acc_at(1), 8'hA2);
        check_eq("stream_w2", acc_at(2), 8'hA3);
        check_eq("stream_cnt", s_cnt, 4'd3);

        // Backpressure then release
        do_reset();
        q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        repeat (5) cycle();
        check_eq("bp_rinc", rinc_h[4:0], 5'b00011);
        check_eq("bp_fifo_left", q.size(), 3);
        check_eq("bp_valid", s_valid, 1'b1);
        check_eq("bp_head", s_data, 8'hB0);
        clear_hist();
        out_ready = 1'b1;
        repeat (8) cycle();
        check_eq("bp_valid_run", vld_h[7:0], 8'b00011111);
        check_eq("bp_n", acc.size(), 5);
        for (int k = 0; k < 5; k++) check_eq("bp_order", acc_at(k), 8'hB0 + 8'(k));
        check_eq("bp_cnt", s_cnt, 4'd5);

        // Alternating ready exercises push+pop at count 1
        do_reset();
        for (int k = 0; k < 8; k++) q.push_back(8'h10 + 8'(k));
        for (int i = 0; i < 24; i++) begin
            out_ready = (i % 2 == 0);
            cycle();
        end
        check_eq("alt_n", acc.size(), 8);
        for (int k = 0; k < 8; k++) check_eq("alt_order", acc_at(k), 8'h10 + 8'(k));
        check_eq("alt_cnt", s_cnt, 4'd8);

        // Flush discards buffered words, pop in flush cycle ignored
        do_reset();
        q = '{8'h55, 8'h66, 8'h77};
        repeat (3) cycle();
        check_eq("fl_fill_rinc", rinc_h[2:0], 3'b011);
        flush = 1'b1; out_ready = 1'b1;
        cycle();
        check_eq("fl_rinc_blocked", s_rinc, 1'b0);
        check_eq("fl_head", s_data, 8'h55);
        flush = 1'b0; out_ready = 1'b0;
        cycle();
        check_eq("fl_valid_after", s_valid, 1'b0);
        check_eq("fl_cnt", s_cnt, 4'd0);
        check_eq("fl_refill_rinc", s_rinc, 1'b1);
        cycle();
        check_eq("fl_next_valid", s_valid, 1'b1);
        check_eq("fl_next_head", s_data, 8'h77);

        // Disabled drain still empties the buffer
        do_reset();
        q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        repeat (3) cycle();
        en = 1'b0; out_ready = 1'b1;
        clear_hist();
        repeat (5) cycle();
        check_eq("en_rinc", rinc_h[4:0], 5'b00000);
        check_eq("en_valid", vld_h[4:0], 5'b00011);
        check_eq("en_w0", acc_at(0), 8'hC1);
        check_eq("en_w1", acc_at(1), 8'hC2);
        check_eq("en_fifo_left", q.size(), 2);
        check_eq("en_cnt", s_cnt, 4'd2);

        // Counter saturation with a 4-bit counter
        do_reset();
        for (int k = 0; k < 20; k++) q.push_back(8'h80 + 8'(k));
        out_ready = 1'b1;
        repeat (25) cycle();
        check_eq("sat_n", acc.size(), 20);
        check_eq("sat_cnt", s_cnt, 4'd15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side drain stage of the asynchronous FIFO, in the read clock domain. It sits directly downstream of the FIFO read pointer/empty logic and the dual-port memory read port. It converts `rempty`/`rdata` into a registered valid/ready stream for the consumer (UART TX path). It generates `rinc` from registered state only, so the consumer's `out_ready` has no combinational path into the FIFO pointer logic.

## Interface
- `DATA_WIDTH`, 8, width of one FIFO word.
- `CNT_WIDTH`, 16, width of the drained-word statistics counter.
- `rclk`  in  1  read-domain clock.
- `rrst`  in  1  synchronous, active-high reset (sampled on `rclk` rising edge).
- `en`  in  1  drain enable. When 0, no new `rinc` is issued, but the buffered words still drain.
- `flush`  in  1  synchronous single-cycle clear of the local buffer.
- `rempty`  in  1  registered FIFO empty flag from the read-pointer stage.
- `rdata`  in  DATA_WIDTH  memory word at the current read address; valid whenever `rempty`=0.
- `rinc`  out  1  read-increment to the read-pointer stage.
- `out_valid`  out  1  head word available.
- `out_data`  out  DATA_WIDTH  head word.
- `out_ready`  in  1  consumer accepts the head word when `out_valid`=1.
- `drain_cnt`  out  CNT_WIDTH  count of words handed to the consumer; saturates at all-ones.

## Operation
- Local storage is a 2-entry buffer: `head`, `tail`, and 2-bit `count` (0..2). The encoding 3 is illegal.
- `rinc` = `en` & ~`rempty` & (`count` < 2) & ~`flush`. It is combinational from registers and inputs `en`/`rempty`/`flush` only. It never depends on `out_ready`.
- Push: when `rinc`=1, `rdata` is written on the same edge. It goes to `head` if the buffer will be empty after this cycle's pop; otherwise it goes to `tail`.
- Pop: `out_valid` & `out_ready`. `tail` moves to `head`, `count` decrements, and `drain_cnt` increments (saturating).
- Simultaneous push and pop: `count` is unchanged and order is preserved.
  - At `count`=1, the new word goes directly to `head`.
  - At `count`=2, there is no push, because the `rinc` gate uses the pre-pop count.
- `out_valid` = (`count` != 0). `out_data` = `head`. Both are driven straight from registers.
- `flush`: `count` goes to 0 on the next edge, and a pop in the same cycle is ignored. `drain_cnt` is not cleared. FIFO contents are untouched; the buffered words are discarded.
- `en`=0: the current buffered words still drain to the consumer. `drain_cnt` keeps counting.
- Word order at `out_data` equals FIFO order. No word is duplicated or dropped except by `flush`.

## Timing
- Reset (`rrst`=1 at an edge): `count`=0, `head`=`tail`=0, `drain_cnt`=0.
  - Hence `out_valid`=0 and `out_data`=0.
  - `rinc`=0 during reset, because it is forced low while `rrst`=1.
- Reset mid-transfer discards the buffered words. Re-aligning the FIFO pointers is the job of the pointer-stage reset.
- Latency:
  - `rempty` falling in cycle N gives `rinc`=1 in cycle N.
  - The word is captured at the end of N, and `out_valid`=1 in N+1.
- Throughput: with `out_ready` held at 1 and a non-empty FIFO, one word per cycle is sustained with `count` at 1.
- Backpressure: when `out_ready`=0, at most 2 words are pulled. `rinc` drops in the cycle after `count` reaches 2.
- `rempty` rises in the cycle after the last `rinc`. This is guaranteed by the pointer stage, and this block issues no `rinc` against an empty flag.
- `drain_cnt` wraps never: at 2^CNT_WIDTH−1, further pops leave it unchanged.

## Structure
- Shared package `fifo_pkg`:
  - `DATA_WIDTH` default.
  - Buffer count type (2-bit) with named constants `CNT_EMPTY`=0, `CNT_ONE`=1, `CNT_FULL`=2.
- One natural sub-module: `skid_buf2`, the 2-entry buffer with push/pop/flush and count.
- The top level holds the `rinc` gating and the `drain_cnt` statistics counter.

## Test plan
- Reset check: hold `rrst`=1 for 3 cycles with `rempty`=0 → `rinc`=0, `out_valid`=0, `out_data`=0, `drain_cnt`=0.
- Streaming: FIFO holds 0xA1,0xA2,0xA3 and `out_ready`=1 → `rinc` high for 3 consecutive cycles; `out_data` shows 0xA1,0xA2,0xA3 on consecutive cycles starting 1 cycle after `rempty` falls; `drain_cnt`=3.
- Backpressure: FIFO holds 5 words and `out_ready`=0 → exactly 2 `rinc` pulses, `count`=2, `out_data`=first word. Then raise `out_ready` → all 5 words emerge in order, with no gap longer than 1 cycle.
- Simultaneous push and pop at `count`=1: alternate `out_ready` 1/0 with words 0x10..0x17 → output order is 0x10..0x17 and `drain_cnt`=8.
- Flush: buffer holds 0x55,0x66 and `flush`=1 with `out_ready`=1 → next cycle `out_valid`=0 and `drain_cnt` unchanged. The next FIFO word (0x77) appears as the head.
- Enable and saturation:
  - `en`=0 with 2 words buffered → both words drain, then no further `rinc`.
  - Separately, preload `drain_cnt` near max (or set CNT_WIDTH=4) and pop 20 words → `drain_cnt`=15.
